// File: rtl/buf_free_list.sv
// buf_free_list: free-address pool feeding ctrlBuf's enqueue side.
// Self-populates NUM_BUFFS addresses after reset or reinit, then serves one
// alloc and one free per cycle from a circular FIFO. Illegal or overflowing
// frees raise a sticky error flag.
module buf_free_list #(
  parameter int unsigned            ADDR_WIDTH  = 64,
  parameter int unsigned            NUM_BUFFS   = 21,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = {ADDR_WIDTH{1'b0}},
  parameter int unsigned            ADDR_STRIDE = 64,
  parameter int unsigned            CNT_WIDTH   = $clog2(NUM_BUFFS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reinit,
  output logic                  init_done,
  output logic                  alloc_valid,
  input  logic                  alloc_ready,
  output logic [ADDR_WIDTH-1:0] alloc_addr,
  input  logic                  free_valid,
  output logic                  free_ready,
  input  logic [ADDR_WIDTH-1:0] free_addr,
  output logic [CNT_WIDTH-1:0]  free_count,
  output logic                  err_bad_free
);

  localparam int unsigned PTR_WIDTH = (NUM_BUFFS > 1) ? $clog2(NUM_BUFFS) : 1;
  localparam int unsigned AW1       = ADDR_WIDTH + 1;
  localparam logic [PTR_WIDTH-1:0]  PTR_LAST    = PTR_WIDTH'(NUM_BUFFS - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_FULL    = CNT_WIDTH'(NUM_BUFFS);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_A    = ADDR_WIDTH'(ADDR_STRIDE);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_MASK = STRIDE_A - ADDR_WIDTH'(1);
  // One past the last legal address, kept one bit wider so it cannot wrap.
  localparam logic [AW1-1:0]        LIMIT_A     = {1'b0, BASE_ADDR} +
                                                  AW1'(NUM_BUFFS) * AW1'(ADDR_STRIDE);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t                  state_r, state_nx;
  logic [PTR_WIDTH-1:0]    rd_ptr_r, rd_ptr_nx;
  logic [PTR_WIDTH-1:0]    wr_ptr_r, wr_ptr_nx;
  logic [CNT_WIDTH-1:0]    count_r, count_nx;
  logic                    err_r, err_nx;
  logic                    init_done_r, init_done_nx;
  logic                    alloc_valid_r, free_ready_r;
  logic [ADDR_WIDTH-1:0]   alloc_addr_r, alloc_addr_nx;
  logic                    wr_en_s;
  logic [ADDR_WIDTH-1:0]   wr_data_s;
  logic                    alloc_fire_s, free_take_s;
  logic [ADDR_WIDTH-1:0]   mem_r [0:NUM_BUFFS-1];

  // Circular pointer advance; NUM_BUFFS need not be a power of two.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? {PTR_WIDTH{1'b0}} : p + PTR_WIDTH'(1);
  endfunction

  // A returned address must be inside the pool window and stride-aligned.
  function automatic logic is_legal_free(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ({1'b0, addr} < LIMIT_A) &&
           ((off & STRIDE_MASK) == {ADDR_WIDTH{1'b0}});
  endfunction

  // Next-state logic: population, alloc/free handshakes, error flag, reinit.
  always_comb begin
    state_nx     = state_r;
    rd_ptr_nx    = rd_ptr_r;
    wr_ptr_nx    = wr_ptr_r;
    count_nx     = count_r;
    err_nx       = err_r;
    init_done_nx = 1'b0;
    wr_en_s      = 1'b0;
    wr_data_s    = {ADDR_WIDTH{1'b0}};
    alloc_fire_s = 1'b0;
    free_take_s  = 1'b0;
    if (reinit) begin
      state_nx  = ST_INIT;
      rd_ptr_nx = {PTR_WIDTH{1'b0}};
      wr_ptr_nx = {PTR_WIDTH{1'b0}};
      count_nx  = {CNT_WIDTH{1'b0}};
      err_nx    = 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          // wr_ptr starts at 0 and advances once per cycle, so it doubles as idx.
          wr_en_s   = 1'b1;
          wr_data_s = BASE_ADDR + ADDR_WIDTH'(wr_ptr_r) * STRIDE_A;
          wr_ptr_nx = ptr_inc(wr_ptr_r);
          count_nx  = count_r + CNT_WIDTH'(1);
          if (wr_ptr_r == PTR_LAST) begin
            state_nx = ST_READY;
          end else begin
            state_nx = ST_INIT;
          end
        end
        ST_READY: begin
          init_done_nx = 1'b1;
          alloc_fire_s = alloc_valid_r & alloc_ready;
          // Accepted frees with a bad address are consumed but dropped.
          free_take_s  = free_valid & free_ready_r & is_legal_free(free_addr);
          if (alloc_fire_s) begin
            rd_ptr_nx = ptr_inc(rd_ptr_r);
          end else begin
            rd_ptr_nx = rd_ptr_r;
          end
          if (free_take_s) begin
            wr_en_s   = 1'b1;
            wr_data_s = free_addr;
            wr_ptr_nx = ptr_inc(wr_ptr_r);
          end else begin
            wr_ptr_nx = wr_ptr_r;
          end
          if (free_take_s && !alloc_fire_s) begin
            count_nx = count_r + CNT_WIDTH'(1);
          end else if (!free_take_s && alloc_fire_s) begin
            count_nx = count_r - CNT_WIDTH'(1);
          end else begin
            count_nx = count_r;
          end
          if (free_valid && init_done_r && (!free_ready_r || !is_legal_free(free_addr))) begin
            err_nx = 1'b1;
          end else begin
            err_nx = err_r;
          end
        end
        default: begin
          state_nx  = ST_INIT;
          rd_ptr_nx = {PTR_WIDTH{1'b0}};
          wr_ptr_nx = {PTR_WIDTH{1'b0}};
          count_nx  = {CNT_WIDTH{1'b0}};
          err_nx    = 1'b0;
        end
      endcase
    end
  end

  // Show-ahead head for next cycle; forward a write landing on the new head slot.
  always_comb begin
    alloc_addr_nx = mem_r[rd_ptr_nx];
    if (reinit) begin
      alloc_addr_nx = {ADDR_WIDTH{1'b0}};
    end else if (wr_en_s && (wr_ptr_r == rd_ptr_nx)) begin
      alloc_addr_nx = wr_data_s;
    end else begin
      alloc_addr_nx = mem_r[rd_ptr_nx];
    end
  end

  // Pool storage; contents are only meaningful behind valid pointers, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_data_s;
    end
  end

  // State, pointers and registered outputs with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_INIT;
      rd_ptr_r      <= {PTR_WIDTH{1'b0}};
      wr_ptr_r      <= {PTR_WIDTH{1'b0}};
      count_r       <= {CNT_WIDTH{1'b0}};
      err_r         <= 1'b0;
      init_done_r   <= 1'b0;
      alloc_valid_r <= 1'b0;
      free_ready_r  <= 1'b0;
      alloc_addr_r  <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r       <= state_nx;
      rd_ptr_r      <= rd_ptr_nx;
      wr_ptr_r      <= wr_ptr_nx;
      count_r       <= count_nx;
      err_r         <= err_nx;
      init_done_r   <= init_done_nx;
      alloc_valid_r <= init_done_nx && (count_nx != {CNT_WIDTH{1'b0}});
      free_ready_r  <= init_done_nx && (count_nx != CNT_FULL);
      alloc_addr_r  <= alloc_addr_nx;
    end
  end

  assign init_done    = init_done_r;
  assign alloc_valid  = alloc_valid_r;
  assign free_ready   = free_ready_r;
  assign alloc_addr   = alloc_addr_r;
  assign free_count   = count_r;
  assign err_bad_free = err_r;

endmodule

// File: tb/tb_buf_free_list.sv
// tb_buf_free_list: directed and random stimulus for buf_free_list, checked
// against a queue-based model of the pool kept in the bench.
module tb_buf_free_list;

  localparam int unsigned AW  = 64;
  localparam int unsigned NB  = 21;
  localparam int unsigned STR = 64;
  localparam int unsigned CW  = $clog2(NB + 1);
  localparam logic [AW-1:0] BASE = 64'd0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          reinit = 1'b0;
  logic          init_done;
  logic          alloc_valid;
  logic          alloc_ready = 1'b0;
  logic [AW-1:0] alloc_addr;
  logic          free_valid = 1'b0;
  logic          free_ready;
  logic [AW-1:0] free_addr = 64'd0;
  logic [CW-1:0] free_count;
  logic          err_bad_free;

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [AW-1:0] q[$];
  logic          err_m;
  logic          serving_m;
  logic          initing_m;
  int            init_idx_m;

  buf_free_list #(.ADDR_WIDTH(AW), .NUM_BUFFS(NB), .BASE_ADDR(BASE), .ADDR_STRIDE(STR)) dut (
    .clk(clk), .rst(rst), .reinit(reinit), .init_done(init_done),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
    .free_valid(free_valid), .free_ready(free_ready), .free_addr(free_addr),
    .free_count(free_count), .err_bad_free(err_bad_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [AW-1:0] a);
    return (a >= BASE) && ((a - BASE) < 64'(NB * STR)) && (((a - BASE) % 64'(STR)) == 64'd0);
  endfunction

  task automatic model_reset();
    q.delete();
    err_m      = 1'b0;
    serving_m  = 1'b0;
    initing_m  = 1'b1;
    init_idx_m = 0;
  endtask

  // Apply one clock edge worth of pool rules using the inputs as held this cycle.
  task automatic model_edge();
    bit full, take_a, take_f;
    if (reinit) begin
      model_reset();
    end else if (initing_m) begin
      q.push_back(BASE + 64'(init_idx_m) * 64'(STR));
      init_idx_m++;
      if (init_idx_m == NB) initing_m = 1'b0;
    end else if (!serving_m) begin
      serving_m = 1'b1;
    end else begin
      full   = (q.size() == NB);
      take_a = (q.size() != 0) && alloc_ready;
      take_f = free_valid && !full;
      if (free_valid && (full || !legal(free_addr))) err_m = 1'b1;
      if (take_a) void'(q.pop_front());
      if (take_f && legal(free_addr)) q.push_back(free_addr);
    end
  endtask

  task automatic check_all();
    chk("init_done", 64'(init_done), 64'(serving_m));
    chk("alloc_valid", 64'(alloc_valid), 64'(serving_m && q.size() != 0));
    chk("free_ready", 64'(free_ready), 64'(serving_m && q.size() != NB));
    chk("free_count", 64'(free_count), 64'(q.size()));
    chk("err_bad_free", 64'(err_bad_free), 64'(err_m));
    if (serving_m && q.size() != 0) chk("alloc_addr", alloc_addr, q[0]);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_init_done"}, 64'(init_done), 64'd0);
    chk({tag, "_alloc_valid"}, 64'(alloc_valid), 64'd0);
    chk({tag, "_free_ready"}, 64'(free_ready), 64'd0);
    chk({tag, "_alloc_addr"}, alloc_addr, 64'd0);
    chk({tag, "_free_count"}, 64'(free_count), 64'd0);
    chk({tag, "_err"}, 64'(err_bad_free), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (!init_done && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_init_cycles"}, 64'(n), 64'(exp_cycles));
  endtask

  initial begin
    logic [AW-1:0] a;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Release reset away from the edge; population starts at the next edge.
    rst = 1'b1;
    wait_ready("por", 22);
    chk("por_count", 64'(free_count), 64'd21);
    chk("por_addr", alloc_addr, 64'd0);

    // Drain the whole pool with alloc_ready held high.
    alloc_ready = 1'b1;
    for (int i = 0; i < NB; i++) begin
      chk("drain_addr", alloc_addr, 64'(i * 64));
      tick();
    end
    alloc_ready = 1'b0;
    chk("drain_valid", 64'(alloc_valid), 64'd0);
    chk("drain_count", 64'(free_count), 64'd0);

    // Free into an empty pool: no bypass in the acceptance cycle.
    free_valid = 1'b1;
    free_addr  = 64'd640;
    chk("empty_accept_valid", 64'(alloc_valid), 64'd0);
    alloc_ready = 1'b1;
    tick();
    alloc_ready = 1'b0;
    free_valid  = 1'b0;
    chk("empty_after_valid", 64'(alloc_valid), 64'd1);
    chk("empty_after_addr", alloc_addr, 64'd640);

    // Build count=5, then alloc and free(128) together.
    free_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = (i < 2) ? 64'(i * 64) : 64'((i + 1) * 64);
      free_addr = a;
      tick();
    end
    free_valid = 1'b0;
    chk("five_count", 64'(free_count), 64'd5);
    alloc_ready = 1'b1;
    free_valid  = 1'b1;
    free_addr   = 64'd128;
    tick();
    free_valid = 1'b0;
    chk("simul_count", 64'(free_count), 64'd5);
    for (int i = 0; i < 5; i++) begin
      a = (i == 4) ? 64'd128 : ((i < 2) ? 64'(i * 64) : 64'((i + 1) * 64));
      chk("simul_order", alloc_addr, a);
      tick();
    end
    alloc_ready = 1'b0;
    chk("simul_empty", 64'(alloc_valid), 64'd0);

    // Misaligned free is consumed, dropped and flagged.
    free_valid = 1'b1;
    free_addr  = 64'd100;
    chk("misalign_ready", 64'(free_ready), 64'd1);
    tick();
    free_valid = 1'b0;
    chk("misalign_err", 64'(err_bad_free), 64'd1);
    chk("misalign_count", 64'(free_count), 64'd0);

    // Reinit clears the error and repopulates; then free into a full pool.
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    chk("reinit_done", 64'(init_done), 64'd0);
    chk("reinit_err", 64'(err_bad_free), 64'd0);
    wait_ready("reinit", 22);
    free_valid = 1'b1;
    free_addr  = 64'd0;
    chk("full_ready", 64'(free_ready), 64'd0);
    tick();
    free_valid = 1'b0;
    chk("full_err", 64'(err_bad_free), 64'd1);
    chk("full_count", 64'(free_count), 64'd21);

    // Random traffic with occasional bad frees and reinit pulses.
    for (int c = 0; c < 600; c++) begin
      alloc_ready = ($urandom_range(0, 99) < 55);
      free_valid  = ($urandom_range(0, 99) < 50);
      case ($urandom_range(0, 9))
        0:       free_addr = 64'($urandom_range(0, 2000)) | 64'd1;
        1:       free_addr = 64'(NB * STR) + 64'($urandom_range(0, 5) * 64);
        default: free_addr = 64'($urandom_range(0, NB - 1) * 64);
      endcase
      reinit = ($urandom_range(0, 149) == 0);
      tick();
    end
    reinit      = 1'b0;
    alloc_ready = 1'b0;
    free_valid  = 1'b0;

    // Async reset during population returns outputs to zero at once.
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midinit");
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_ready("rerst", 22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound the whole run so a stuck design cannot hang the bench.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
